// File: rtl/id_exm_regs_if.sv
// ID -> EX/MEM pipeline register bundle: ID-side fields, hazard controls and registered EX-side copies.
// master drives the ID side and observes the stage outputs; slave is the pipeline register itself.
interface id_exm_regs_if;
    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALUSEL_W = 4;
    localparam int unsigned MEMWEN_W = 4;
    localparam int unsigned LDSEL_W  = 3;
    localparam int unsigned WBSEL_W  = 2;

    // hazard controls
    logic                stall;
    logic                flush;

    // ID-stage fields
    logic [XLEN-1:0]     pc;
    logic [XLEN-1:0]     rs1;
    logic [XLEN-1:0]     rs2;
    logic [XLEN-1:0]     imm;
    logic                BrUn;
    logic                BSel;
    logic                ASel;
    logic [ALUSEL_W-1:0] ALUSel;
    logic [MEMWEN_W-1:0] MEMWen;
    logic                CSRSrc;
    logic [LDSEL_W-1:0]  LDSel;
    logic [WBSEL_W-1:0]  WBSel;
    logic                RegWen;
    logic [XLEN-1:0]     Inst;

    // EX/MEM-stage copies
    logic [XLEN-1:0]     pc_o;
    logic [XLEN-1:0]     rs1_o;
    logic [XLEN-1:0]     rs2_o;
    logic [XLEN-1:0]     imm_o;
    logic                BrUn_o;
    logic                BSel_o;
    logic                ASel_o;
    logic [ALUSEL_W-1:0] ALUSel_o;
    logic [MEMWEN_W-1:0] MEMWen_o;
    logic                CSRSrc_o;
    logic [LDSEL_W-1:0]  LDSel_o;
    logic [WBSEL_W-1:0]  WBSel_o;
    logic                RegWen_o;
    logic [XLEN-1:0]     Inst_o;

    modport master (
        output stall, flush,
        output pc, rs1, rs2, imm, BrUn, BSel, ASel, ALUSel, MEMWen, CSRSrc, LDSel, WBSel, RegWen, Inst,
        input  pc_o, rs1_o, rs2_o, imm_o, BrUn_o, BSel_o, ASel_o, ALUSel_o, MEMWen_o,
        input  CSRSrc_o, LDSel_o, WBSel_o, RegWen_o, Inst_o
    );

    modport slave (
        input  stall, flush,
        input  pc, rs1, rs2, imm, BrUn, BSel, ASel, ALUSel, MEMWen, CSRSrc, LDSel, WBSel, RegWen, Inst,
        output pc_o, rs1_o, rs2_o, imm_o, BrUn_o, BSel_o, ASel_o, ALUSel_o, MEMWen_o,
        output CSRSrc_o, LDSel_o, WBSel_o, RegWen_o, Inst_o
    );
endinterface

// File: rtl/id_exm_regs.sv
// ID -> EX/MEM pipeline register of the 3-stage RV32 core.
// One-cycle latency; priority per edge is rst > flush > stall > load, reset and flush load a NOP bubble.
module id_exm_regs #(
    parameter logic [31:0] NOP_INST = 32'h0000_0013,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    id_exm_regs_if.slave  bus
);
    localparam int unsigned XLEN     = 32;
    localparam int unsigned ALUSEL_W = 4;
    localparam int unsigned MEMWEN_W = 4;
    localparam int unsigned LDSEL_W  = 3;
    localparam int unsigned WBSEL_W  = 2;

    typedef struct packed {
        logic [XLEN-1:0]     pc;
        logic [XLEN-1:0]     rs1;
        logic [XLEN-1:0]     rs2;
        logic [XLEN-1:0]     imm;
        logic                br_un;
        logic                b_sel;
        logic                a_sel;
        logic [ALUSEL_W-1:0] alu_sel;
        logic [MEMWEN_W-1:0] mem_wen;
        logic                csr_src;
        logic [LDSEL_W-1:0]  ld_sel;
        logic [WBSEL_W-1:0]  wb_sel;
        logic                reg_wen;
        logic [XLEN-1:0]     inst;
    } stage_t;

    stage_t stage_q;
    stage_t stage_d;
    stage_t stage_in;
    stage_t bubble;

    // Bubble carries no architectural side effect: no regfile write, no store strobe.
    always_comb begin
        bubble      = '0;
        bubble.pc   = RESET_PC;
        bubble.inst = NOP_INST;
    end

    always_comb begin
        stage_in         = '0;
        stage_in.pc      = bus.pc;
        stage_in.rs1     = bus.rs1;
        stage_in.rs2     = bus.rs2;
        stage_in.imm     = bus.imm;
        stage_in.br_un   = bus.BrUn;
        stage_in.b_sel   = bus.BSel;
        stage_in.a_sel   = bus.ASel;
        stage_in.alu_sel = bus.ALUSel;
        stage_in.mem_wen = bus.MEMWen;
        stage_in.csr_src = bus.CSRSrc;
        stage_in.ld_sel  = bus.LDSel;
        stage_in.wb_sel  = bus.WBSel;
        stage_in.reg_wen = bus.RegWen;
        stage_in.inst    = bus.Inst;
    end

    // Flush wins over stall so a held stage can still be squashed.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = bubble;
        end else if (!bus.stall) begin
            stage_d = stage_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stage_q <= bubble;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign bus.pc_o     = stage_q.pc;
    assign bus.rs1_o    = stage_q.rs1;
    assign bus.rs2_o    = stage_q.rs2;
    assign bus.imm_o    = stage_q.imm;
    assign bus.BrUn_o   = stage_q.br_un;
    assign bus.BSel_o   = stage_q.b_sel;
    assign bus.ASel_o   = stage_q.a_sel;
    assign bus.ALUSel_o = stage_q.alu_sel;
    assign bus.MEMWen_o = stage_q.mem_wen;
    assign bus.CSRSrc_o = stage_q.csr_src;
    assign bus.LDSel_o  = stage_q.ld_sel;
    assign bus.WBSel_o  = stage_q.wb_sel;
    assign bus.RegWen_o = stage_q.reg_wen;
    assign bus.Inst_o   = stage_q.inst;
endmodule

// File: tb/tb_id_exm_regs.sv
// Self-checking bench for id_exm_regs: vector table driven 4ns after each posedge,
// expected stage contents queued at drive time and popped 1ns after the capturing edge.
module tb_id_exm_regs;
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic        brun;
        logic        bsel;
        logic        asel;
        logic [3:0]  alusel;
        logic [3:0]  memwen;
        logic        csrsrc;
        logic [2:0]  ldsel;
        logic [1:0]  wbsel;
        logic        regwen;
        logic [31:0] inst;
    } pay_t;

    typedef enum logic [1:0] {EXP_IN, EXP_HOLD, EXP_BUBBLE} exp_kind_t;

    typedef struct {
        string     name;
        logic      rst;
        logic      flush;
        logic      stall;
        pay_t      din;
        exp_kind_t kind;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    id_exm_regs_if bus ();

    id_exm_regs dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_cmp  = 0;
    int   n_fail = 0;
    pay_t sb_q[$];
    pay_t last_exp;
    bit   have_last = 1'b0;
    vec_t vecs[$];

    function automatic pay_t bubble_val();
        pay_t b;
        b      = '0;
        b.inst = 32'h0000_0013;
        b.pc   = 32'h0000_0000;
        return b;
    endfunction

    function automatic pay_t rand_pay();
        pay_t p;
        p.pc     = $urandom;
        p.rs1    = $urandom;
        p.rs2    = $urandom;
        p.imm    = $urandom;
        p.brun   = 1'($urandom_range(1));
        p.bsel   = 1'($urandom_range(1));
        p.asel   = 1'($urandom_range(1));
        p.alusel = 4'($urandom_range(15));
        p.memwen = 4'($urandom_range(15));
        p.csrsrc = 1'($urandom_range(1));
        p.ldsel  = 3'($urandom_range(7));
        p.wbsel  = 2'($urandom_range(3));
        p.regwen = 1'($urandom_range(1));
        p.inst   = $urandom;
        return p;
    endfunction

    function automatic pay_t read_out();
        pay_t p;
        p.pc     = bus.pc_o;
        p.rs1    = bus.rs1_o;
        p.rs2    = bus.rs2_o;
        p.imm    = bus.imm_o;
        p.brun   = bus.BrUn_o;
        p.bsel   = bus.BSel_o;
        p.asel   = bus.ASel_o;
        p.alusel = bus.ALUSel_o;
        p.memwen = bus.MEMWen_o;
        p.csrsrc = bus.CSRSrc_o;
        p.ldsel  = bus.LDSel_o;
        p.wbsel  = bus.WBSel_o;
        p.regwen = bus.RegWen_o;
        p.inst   = bus.Inst_o;
        return p;
    endfunction

    task automatic drive(input logic r, input logic f, input logic s, input pay_t p);
        rst        = r;
        bus.flush  = f;
        bus.stall  = s;
        bus.pc     = p.pc;
        bus.rs1    = p.rs1;
        bus.rs2    = p.rs2;
        bus.imm    = p.imm;
        bus.BrUn   = p.brun;
        bus.BSel   = p.bsel;
        bus.ASel   = p.asel;
        bus.ALUSel = p.alusel;
        bus.MEMWen = p.memwen;
        bus.CSRSrc = p.csrsrc;
        bus.LDSel  = p.ldsel;
        bus.WBSel  = p.wbsel;
        bus.RegWen = p.regwen;
        bus.Inst   = p.inst;
    endtask

    task automatic check(input string name, input pay_t act, input pay_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Entered 1ns after a posedge; leaves 1ns after the next posedge.
    task automatic apply(input vec_t v);
        pay_t exp;
        #3;
        drive(v.rst, v.flush, v.stall, v.din);
        case (v.kind)
            EXP_IN:   exp = v.din;
            EXP_HOLD: exp = last_exp;
            default:  exp = bubble_val();
        endcase
        sb_q.push_back(exp);
        #1;
        if (have_last) check({v.name, "/pre_edge"}, read_out(), last_exp);
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL %s: scoreboard empty got %h want entry", v.name, read_out());
        end else begin
            exp = sb_q.pop_front();
            check(v.name, read_out(), exp);
            last_exp  = exp;
            have_last = 1'b1;
        end
    endtask

    function automatic vec_t mk(input string n, input logic r, input logic f, input logic s,
                                input pay_t p, input exp_kind_t k);
        vec_t v;
        v.name  = n;
        v.rst   = r;
        v.flush = f;
        v.stall = s;
        v.din   = p;
        v.kind  = k;
        return v;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        pay_t ld;
        pay_t ld99;
        pay_t p;

        ld.pc = 32'd1234;  ld.rs1 = 32'd2345;  ld.rs2 = 32'd3456;  ld.imm = 32'd4567;
        ld.brun = 1'b1;    ld.bsel = 1'b1;     ld.asel = 1'b1;     ld.alusel = 4'd3;
        ld.memwen = 4'h5;  ld.csrsrc = 1'b1;   ld.ldsel = 3'd2;    ld.wbsel = 2'd2;
        ld.regwen = 1'b1;  ld.inst = 32'd1345;
        ld99    = ld;
        ld99.pc = 32'd99;

        vecs.push_back(mk("reset0",       1'b1, 1'b0, 1'b0, rand_pay(), EXP_BUBBLE));
        vecs.push_back(mk("reset1",       1'b1, 1'b0, 1'b0, rand_pay(), EXP_BUBBLE));
        vecs.push_back(mk("load",         1'b0, 1'b0, 1'b0, ld,         EXP_IN));
        vecs.push_back(mk("stall_pc99_a", 1'b0, 1'b0, 1'b1, ld99,       EXP_HOLD));
        vecs.push_back(mk("stall_pc99_b", 1'b0, 1'b0, 1'b1, ld99,       EXP_HOLD));
        vecs.push_back(mk("unstall_pc99", 1'b0, 1'b0, 1'b0, ld99,       EXP_IN));
        vecs.push_back(mk("flush_stall",  1'b0, 1'b1, 1'b1, ld,         EXP_BUBBLE));
        vecs.push_back(mk("reload",       1'b0, 1'b0, 1'b0, rand_pay(), EXP_IN));
        vecs.push_back(mk("flush_only",   1'b0, 1'b1, 1'b0, rand_pay(), EXP_BUBBLE));
        vecs.push_back(mk("reload2",      1'b0, 1'b0, 1'b0, ld,         EXP_IN));
        vecs.push_back(mk("rst_stall",    1'b1, 1'b0, 1'b1, rand_pay(), EXP_BUBBLE));
        vecs.push_back(mk("post_rst",     1'b0, 1'b0, 1'b0, rand_pay(), EXP_IN));
        for (int i = 0; i < 12; i++) begin
            vecs.push_back(mk($sformatf("b2b%0d", i), 1'b0, 1'b0, 1'b0, rand_pay(), EXP_IN));
        end
        vecs.push_back(mk("all_ones",     1'b0, 1'b0, 1'b0, '1,         EXP_IN));
        vecs.push_back(mk("all_zero",     1'b0, 1'b0, 1'b0, '0,         EXP_IN));

        drive(1'b1, 1'b0, 1'b0, '0);
        @(posedge clk);
        #1;
        foreach (vecs[i]) apply(vecs[i]);

        // Long stall with inputs changing every cycle, then release.
        apply(mk("pre_long", 1'b0, 1'b0, 1'b0, rand_pay(), EXP_IN));
        for (int i = 0; i < 5; i++) begin
            apply(mk($sformatf("long_stall%0d", i), 1'b0, 1'b0, 1'b1, rand_pay(), EXP_HOLD));
        end
        apply(mk("long_release", 1'b0, 1'b0, 1'b0, rand_pay(), EXP_IN));

        // Reset held across a stall window; first free edge after reset captures.
        apply(mk("rst_hold0", 1'b1, 1'b1, 1'b1, rand_pay(), EXP_BUBBLE));
        apply(mk("rst_hold1", 1'b1, 1'b0, 1'b0, rand_pay(), EXP_BUBBLE));
        apply(mk("stall_bub", 1'b0, 1'b0, 1'b1, rand_pay(), EXP_HOLD));
        apply(mk("resume",    1'b0, 1'b0, 1'b0, rand_pay(), EXP_IN));

        n_cmp++;
        if (sb_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: got %0d left want 0", sb_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
